expander: RTL and testbench
===========================

// Module: expander
// PURPOSE
//  Inverse of the sample compaction stage: takes a packed sample word
//  (selected channels squeezed into LSBs) and scatters it back to the
//  channel positions marked in cfg_mask, zeroing unselected positions.
//  Sits on the readout path before sample display/export.
//  Pipelined log2(DW)-stage butterfly with valid/ready streams and bypass.
// PARAMETERS
//  DW  32  data width in bits (power of 2, >=4); DL=$clog2(DW) pipe stages
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  ctl_clr    in   1   sync flush: drop all words in the pipeline
//  ctl_ena    in   1   1 = expand through pipeline, 0 = combinational bypass
//  cfg_mask   in   DW  1 = channel position to be filled from packed data
//  sti_valid  in   1   input word valid
//  sti_ready  out  1   input word accepted when sti_valid & sti_ready
//  sti_data   in   DW  packed word, LSB = lowest selected channel
//  sto_valid  out  1   output word valid
//  sto_ready  in   1   downstream accepts when sto_valid & sto_ready
//  sto_data   out  DW  expanded word
// BEHAVIOUR
//  Function: let p(k) = popcount(cfg_mask[k-1:0]).
//   sto_data[k] = cfg_mask[k] ? sti_data[p(k)] : 0.
//   Packed bits at index >= popcount(cfg_mask) are ignored.
//  Control: per-bit stage-select ctl[k][l] is derived from cfg_mask and
//   registered on every cycle with ctl_ena=0; frozen while ctl_ena=1.
//   cfg_mask changes while ctl_ena=1 have no effect until the next
//   cycle with ctl_ena=0.
//  Datapath: DL register stages; stages apply left shifts of
//   2^(DL-1), ..., 2, 1 in that order (reverse of compaction), with each
//   bit selecting shifted or unshifted per ctl. Network must be collision
//   free; unselected output bits masked to 0 in the last stage.
//  Handshake (ctl_ena=1): adv = ~pipe_valid[DL-1] | sto_ready.
//   adv=1: all stages shift one step; stage0 loads sti_data, valid=sti_valid.
//   adv=0: whole pipeline holds, stage data and valid unchanged.
//   sti_ready = adv. sto_valid = pipe_valid[DL-1]; sto_data = last stage.
//   Latency: word accepted in cycle c appears on sto in cycle c+DL when
//   unstalled; throughput one word/cycle; order preserved; no loss.
//  Bypass (ctl_ena=0): sto_valid=sti_valid, sto_data=sti_data,
//   sti_ready=sto_ready (combinational); all pipe_valid bits cleared each
//   cycle, so words in flight at ctl_ena fall are discarded.
//  ctl_clr=1 (either mode): all pipe_valid <= 0 next edge; pipe data don't
//   care. If ctl_clr and an input transfer coincide, the input is dropped.
//  Reset (rst_n=0, async): pipe_valid=0, pipe data=0, ctl=0 (identity).
//   Outputs during/after reset with ctl_ena=1: sto_valid=0, sto_data=0,
//   sti_ready=1. Reset mid-stream discards all in-flight words.
//  Edge masks: cfg_mask=all ones -> identity; cfg_mask=0 -> sto_data=0
//   for every word (valid still propagates).
// TESTING
//  DW=8, mask=8'hA5, ctl_ena=1: in 8'h0F -> out 8'hA5; 8'h05 -> 8'h21;
//   8'hF0 -> 8'h00; each out exactly 3 cycles after accept.
//  mask=8'hFF -> random 1000 words out unchanged; mask=8'h00 -> all 8'h00.
//  Stream 6 words, sto_ready low 5 cycles mid-stream -> sti_ready drops
//   once pipe full, all 6 out in order, none duplicated.
//  ctl_ena=0: sto_data follows sti_data same cycle, sti_ready==sto_ready;
//   mask change 8'hA5->8'h0F under ctl_ena=1 has no effect until ena low.
//  ctl_clr with 3 words in flight -> sto_valid=0 next cycle, no words out.
//  rst_n pulse mid-stream -> sto_valid=0, sto_data=0 immediately; fresh
//   stream afterwards expands correctly; randomised vs reference model.

Source files
------------

// File: rtl/expander.sv
// Sample expander: scatters a packed sample word back to the channel
// positions selected by cfg_mask through a log2(DW)-stage butterfly
// (left shifts 2^(DL-1) .. 1), with a valid/ready stream and a
// combinational bypass when the pipeline is disabled.

// One butterfly stage: each bit takes either its own input or the input
// SH positions below it. Bits below SH have no source and shift in 0.
module expander_stage #(
  parameter int DW = 32,
  parameter int SH = 1
) (
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] sel,
  output logic [DW-1:0] dout
);
  for (genvar k = 0; k < DW; k++) begin : g_bit
    if (k >= SH) begin : g_sh
      assign dout[k] = sel[k] ? din[k-SH] : din[k];
    end else begin : g_lo
      assign dout[k] = sel[k] ? 1'b0 : din[k];
    end
  end
endmodule

module expander #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ctl_clr,
  input  logic          ctl_ena,
  input  logic [DW-1:0] cfg_mask,
  input  logic          sti_valid,
  output logic          sti_ready,
  input  logic [DW-1:0] sti_data,
  output logic          sto_valid,
  input  logic          sto_ready,
  output logic [DW-1:0] sto_data
);
  localparam int DL = $clog2(DW);

  // ctl_q[j][pos]: at the stage shifting by 2^j, bit pos takes pos-2^j
  logic [DL-1:0][DW-1:0] ctl_q, ctl_nxt;
  logic [DW-1:0]         mask_q;
  logic [DL:1]           vld_pipe;   // vld_pipe[s+1] = stage s holds a word
  logic [DL-1:0]         ld_vld;     // valid of the word entering stage s
  logic [DL-1:0][DW-1:0] data_q, stg_out;
  logic                  adv;

  // Control derivation. A selected channel k sits at packed index p(k), so
  // it travels left by d = k - p(k). Stages run from the largest shift
  // down; before the stage of shift 2^j the word has already covered the
  // high part of d, so it lands at k - (d mod 2^j) after this stage. That
  // landing position selects the shifted input when bit j of d is set.
  // Distinct channels never claim the same landing position, so the
  // network is collision free; unclaimed positions carry junk that the
  // final mask removes.
  always_comb begin
    int cnt;
    int d;
    logic [DL-1:0] pos;
    ctl_nxt = '0;
    cnt     = 0;
    d       = 0;
    pos     = '0;
    for (int k = 0; k < DW; k++) begin
      d = k - cnt;
      if (cfg_mask[k]) begin
        for (int j = 0; j < DL; j++) begin
          if (((d >> j) & 1) == 1) begin
            pos = DL'(k - (d & ((1 << j) - 1)));
            ctl_nxt[j][pos] = 1'b1;
          end
        end
        cnt = cnt + 1;
      end
    end
  end

  // Control and mask track cfg_mask only while the pipeline is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q  <= '0;
      mask_q <= '1;
    end else if (!ctl_ena) begin
      ctl_q  <= ctl_nxt;
      mask_q <= cfg_mask;
    end
  end

  assign adv    = ~vld_pipe[DL] | sto_ready;
  assign ld_vld = {vld_pipe[DL-1:1], sti_valid};

  // Valid shift register: flushed by clear or bypass, frozen on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    vld_pipe <= '0;
    else if (ctl_clr || !ctl_ena)  vld_pipe <= '0;
    else if (adv)                  vld_pipe <= {vld_pipe[DL-1:1], sti_valid};
  end

  for (genvar s = 0; s < DL; s++) begin : g_stg
    logic [DW-1:0] din;
    if (s == 0) begin : g_first
      assign din = sti_data;
    end else begin : g_next
      assign din = data_q[s-1];
    end
    expander_stage #(.DW(DW), .SH(1 << (DL-1-s))) u_stg (
      .din  (din),
      .sel  (ctl_q[DL-1-s]),
      .dout (stg_out[s])
    );
  end

  // Stage data moves only with a valid word so bubbles leave it untouched;
  // the last stage zeroes unselected channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (ctl_ena && adv) begin
      for (int s = 0; s < DL; s++) begin
        if (ld_vld[s]) begin
          if (s == DL-1) data_q[s] <= stg_out[s] & mask_q;
          else           data_q[s] <= stg_out[s];
        end
      end
    end
  end

  assign sto_valid = ctl_ena ? vld_pipe[DL]   : sti_valid;
  assign sto_data  = ctl_ena ? data_q[DL-1]   : sti_data;
  assign sti_ready = ctl_ena ? adv            : sto_ready;

endmodule

// File: tb/tb_expander.sv
// Bench for expander (DW=8): directed steps plus randomized traffic, all
// checked every cycle against a reference that expands words with plain
// bit counting and tracks the stream as a DL-deep delay line.
module tb_expander;
  localparam int DW = 8;
  localparam int DL = 3;

  logic          clk = 1'b0;
  logic          rst_n, ctl_clr, ctl_ena, sti_valid, sti_ready, sto_valid, sto_ready;
  logic [DW-1:0] cfg_mask, sti_data, sto_data;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  bit            m_vld [DL];
  logic [DW-1:0] m_dat [DL];
  logic [DW-1:0] m_mask;

  bit            last_v, last_acc, saw_stall;
  logic [DW-1:0] last_d;
  int            n_out;
  logic [DW-1:0] outq [$];
  logic [DW-1:0] wdat [6];

  always #5 clk = ~clk;

  expander #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctl_clr   (ctl_clr),
    .ctl_ena   (ctl_ena),
    .cfg_mask  (cfg_mask),
    .sti_valid (sti_valid),
    .sti_ready (sti_ready),
    .sti_data  (sti_data),
    .sto_valid (sto_valid),
    .sto_ready (sto_ready),
    .sto_data  (sto_data)
  );

  // reference expansion: fill selected positions from packed LSBs upward
  function automatic logic [DW-1:0] expand(input logic [DW-1:0] m, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    int j;
    r = '0;
    j = 0;
    for (int k = 0; k < DW; k++) begin
      if (m[k]) begin
        r[k] = d[j];
        j++;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < DL; s++) begin
      m_vld[s] = 1'b0;
      m_dat[s] = '0;
    end
    m_mask = '1;
  endtask

  // One clock: drive at negedge, check outputs, update reference at posedge
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit rdy);
    bit            ev, er;
    logic [DW-1:0] ed;
    sti_valid = v;
    sti_data  = d;
    sto_ready = rdy;
    #1;
    if (ctl_ena) begin
      ev = m_vld[DL-1];
      ed = m_dat[DL-1];
      er = !m_vld[DL-1] || rdy;
    end else begin
      ev = v;
      ed = d;
      er = rdy;
    end
    chk("sto_valid", DW'(sto_valid), DW'(ev));
    chk("sti_ready", DW'(sti_ready), DW'(er));
    if (ev) chk("sto_data", sto_data, ed);
    last_v   = sto_valid;
    last_d   = sto_data;
    last_acc = v && sti_ready;
    if (v && !sti_ready) saw_stall = 1'b1;
    if (sto_valid && rdy) begin
      n_out++;
      outq.push_back(sto_data);
    end
    @(posedge clk);
    if (!ctl_ena || ctl_clr) begin
      for (int s = 0; s < DL; s++) m_vld[s] = 1'b0;
    end else if (er) begin
      for (int s = DL-1; s > 0; s--) begin
        m_vld[s] = m_vld[s-1];
        m_dat[s] = m_dat[s-1];
      end
      m_vld[0] = v;
      m_dat[0] = expand(m_mask, d);
    end
    if (!ctl_ena) m_mask = cfg_mask;
    @(negedge clk);
  endtask

  task automatic load_mask(input logic [DW-1:0] m);
    ctl_ena  = 1'b0;
    cfg_mask = m;
    cyc(1'b0, '0, 1'b1);
    ctl_ena  = 1'b1;
  endtask

  initial begin
    int idx;
    rst_n = 1'b0; ctl_clr = 1'b0; ctl_ena = 1'b1; cfg_mask = '0;
    sti_valid = 1'b0; sti_data = '0; sto_ready = 1'b0;
    saw_stall = 1'b0; n_out = 0;
    model_reset();
    wdat = '{8'h0F, 8'h05, 8'hF0, 8'hFF, 8'hAA, 8'h33};
    repeat (2) @(negedge clk);
    chk("rst_valid", DW'(sto_valid), '0);
    chk("rst_data",  sto_data, '0);
    chk("rst_ready", DW'(sti_ready), DW'(1'b1));
    rst_n = 1'b1;

    // directed A5 vectors and exact latency
    ctl_ena = 1'b0; cfg_mask = 8'hA5;
    cyc(1'b1, 8'h3C, 1'b1);
    ctl_ena = 1'b1;
    cyc(1'b1, 8'h0F, 1'b1);
    cyc(1'b1, 8'h05, 1'b1);
    cyc(1'b1, 8'hF0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("lat_v0", DW'(last_v), DW'(1'b1));
    chk("a5_0f", last_d, 8'hA5);
    cyc(1'b0, '0, 1'b1);
    chk("a5_05", last_d, 8'h21);
    cyc(1'b0, '0, 1'b1);
    chk("a5_f0", last_d, 8'h00);
    cyc(1'b0, '0, 1'b1);

    // all-ones mask: identity on random traffic
    load_mask(8'hFF);
    repeat (1000) cyc(($urandom % 4) != 0, DW'($urandom), ($urandom % 4) != 0);
    // zero mask: everything expands to 0
    load_mask(8'h00);
    repeat (100) cyc(($urandom % 4) != 0, DW'($urandom), ($urandom % 4) != 0);

    // backpressure: 6 words, downstream stalls 5 cycles mid-stream
    load_mask(8'hA5);
    n_out = 0; outq.delete(); idx = 0; saw_stall = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cyc(idx < 6, (idx < 6) ? wdat[idx] : '0, !(c >= 3 && c < 8));
      if (last_acc) idx++;
    end
    chk("bp_stall", DW'(saw_stall), DW'(1'b1));
    chk("bp_count", DW'(n_out), DW'(6));
    for (int i = 0; i < 6; i++)
      if (i < outq.size()) chk("bp_order", outq[i], expand(8'hA5, wdat[i]));

    // mask change while enabled is ignored until the next disabled cycle
    cfg_mask = 8'h0F;
    cyc(1'b1, 8'h0F, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b1);
    chk("frozen", last_d, 8'hA5);
    load_mask(8'h0F);
    cyc(1'b1, 8'h0F, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b1);
    chk("reloaded", last_d, 8'h0F);

    // bypass follows inputs combinationally
    ctl_ena = 1'b0;
    repeat (20) cyc(($urandom % 2) != 0, DW'($urandom), ($urandom % 2) != 0);

    // clear with three words in flight
    load_mask(8'hA5);
    repeat (3) cyc(1'b1, DW'($urandom), 1'b1);
    n_out = 0;
    ctl_clr = 1'b1;
    cyc(1'b1, 8'h77, 1'b0);
    ctl_clr = 1'b0;
    repeat (6) cyc(1'b0, '0, 1'b1);
    chk("clr_none", DW'(n_out), '0);

    // asynchronous reset mid-stream
    load_mask(8'h5A);
    repeat (2) cyc(1'b1, DW'($urandom), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", DW'(sto_valid), '0);
    chk("arst_data",  sto_data, '0);
    chk("arst_ready", DW'(sti_ready), DW'(1'b1));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic with mask, enable and clear activity
    load_mask(DW'($urandom));
    for (int c = 0; c < 1500; c++) begin
      ctl_ena = ($urandom % 16) != 0;
      ctl_clr = ($urandom % 32) == 0;
      if (($urandom % 8) == 0) cfg_mask = DW'($urandom);
      cyc(($urandom % 4) != 0, DW'($urandom), ($urandom % 4) != 0);
    end
    ctl_clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
